// File: rtl/srt_r4.sv
// srt_r4: free-running unsigned divider, radix-4 SRT with digit set {-2..+2}.
// Samples op1_i/op2_i, iterates WIDTH/2+1 digits, and registers quo_o/rem_o.
// The latency is fixed at WIDTH/2+5 cycles, including capture and output.
module srt_r4 #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] op1_i,
  input  logic [WIDTH-1:0] op2_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  localparam int unsigned ITERS = WIDTH / 2 + 1;
  localparam int unsigned RW    = WIDTH + 4;
  localparam int unsigned CW    = $clog2(ITERS + 1);
  localparam int unsigned KW    = $clog2(WIDTH);

  typedef enum logic [2:0] {S_IDLE, S_NORM, S_ITER, S_CORR, S_DONE} state_t;

  state_t                r_state;
  logic [WIDTH-1:0]      r_op1, r_op2;
  logic [KW-1:0]         r_k;
  logic [WIDTH-1:0]      r_d;
  logic signed [RW-1:0]  r_rem;
  logic [WIDTH+1:0]      r_low;
  logic [WIDTH-1:0]      r_q, r_qm;
  logic [CW-1:0]         r_cnt;
  logic                  r_div0;
  logic [WIDTH-1:0]      r_quo_res, r_rem_res;

  logic [KW-1:0]         w_k;
  logic [2*WIDTH-1:0]    w_n;
  logic [WIDTH-1:0]      w_dn;
  logic signed [RW-1:0]  w_shift, w_dx, w_d2, w_qd, w_next;
  logic signed [6:0]     w_est, w_m2, w_m1;
  logic [WIDTH-1:0]      w_q4, w_qm4, w_qn, w_qmn;
  logic [WIDTH-1:0]      w_rfix, w_rres, w_qres;

  // Normalisation: leading-zero count of the divisor and the shifted operands.
  always_comb begin
    w_k = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (r_op2[i]) w_k = KW'(WIDTH - 1 - i);
    end
    w_n  = {{WIDTH{1'b0}}, r_op1} << w_k;
    w_dn = r_op2 << w_k;
  end

  // One radix-4 step: digit selection, remainder update, on-the-fly quotient.
  // The dividend is fed two bits per step from r_low, so the remainder register
  // only ever holds the active window of the shifted dividend.
  // Selection looks at 7 remainder bits (1/16 resolution) and the three bits of
  // d below its leading one; those thresholds cover the whole d interval.
  always_comb begin
    w_shift = (r_rem <<< 2) | {{(RW-2){1'b0}}, r_low[WIDTH+1:WIDTH]};
    w_est   = w_shift[WIDTH+2 -: 7];
    w_dx    = {4'b0000, r_d};
    w_d2    = w_dx + w_dx;
    w_q4    = r_q << 2;
    w_qm4   = r_qm << 2;
    case (r_d[WIDTH-2 -: 3])
      3'd0:    begin w_m2 = 7'sd12; w_m1 = 7'sd4; end
      3'd1:    begin w_m2 = 7'sd14; w_m1 = 7'sd4; end
      3'd2:    begin w_m2 = 7'sd15; w_m1 = 7'sd5; end
      3'd3:    begin w_m2 = 7'sd16; w_m1 = 7'sd5; end
      3'd4:    begin w_m2 = 7'sd18; w_m1 = 7'sd6; end
      3'd5:    begin w_m2 = 7'sd19; w_m1 = 7'sd6; end
      3'd6:    begin w_m2 = 7'sd20; w_m1 = 7'sd7; end
      default: begin w_m2 = 7'sd22; w_m1 = 7'sd7; end
    endcase
    if (w_est >= w_m2) begin                 // q = +2
      w_qd = w_d2;  w_qn = w_q4 | WIDTH'(2); w_qmn = w_q4 | WIDTH'(1);
    end else if (w_est >= w_m1) begin        // q = +1
      w_qd = w_dx;  w_qn = w_q4 | WIDTH'(1); w_qmn = w_q4;
    end else if (w_est >= -w_m1) begin       // q = 0
      w_qd = '0;    w_qn = w_q4;             w_qmn = w_qm4 | WIDTH'(3);
    end else if (w_est >= -w_m2) begin       // q = -1
      w_qd = -w_dx; w_qn = w_qm4 | WIDTH'(3); w_qmn = w_qm4 | WIDTH'(2);
    end else begin                           // q = -2
      w_qd = -w_d2; w_qn = w_qm4 | WIDTH'(2); w_qmn = w_qm4 | WIDTH'(1);
    end
    w_next = w_shift - w_qd;
  end

  // Final correction: restore a negative remainder and undo the normalisation.
  always_comb begin
    w_rfix = r_rem[RW-1] ? (r_rem[WIDTH-1:0] + r_d) : r_rem[WIDTH-1:0];
    w_rres = w_rfix >> r_k;
    w_qres = r_div0 ? '1 : (r_rem[RW-1] ? r_qm : r_q);
  end

  // Sequencer and datapath registers; outputs change only in DONE.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= S_IDLE;
      r_op1     <= '0;
      r_op2     <= '0;
      r_k       <= '0;
      r_d       <= '0;
      r_rem     <= '0;
      r_low     <= '0;
      r_q       <= '0;
      r_qm      <= '0;
      r_cnt     <= '0;
      r_div0    <= 1'b0;
      r_quo_res <= '0;
      r_rem_res <= '0;
      quo_o     <= '0;
      rem_o     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_op1   <= op1_i;
          r_op2   <= op2_i;
          r_state <= S_NORM;
        end
        S_NORM: begin
          r_k     <= w_k;
          r_d     <= w_dn;
          r_rem   <= RW'(w_n >> (WIDTH + 2));
          r_low   <= w_n[WIDTH+1:0];
          r_q     <= '0;
          r_qm    <= '0;
          r_cnt   <= CW'(ITERS);
          r_div0  <= (r_op2 == '0);
          r_state <= S_ITER;
        end
        S_ITER: begin
          if (!r_div0) begin
            r_rem <= w_next;
            r_low <= r_low << 2;
            r_q   <= w_qn;
            r_qm  <= w_qmn;
          end
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) r_state <= S_CORR;
        end
        S_CORR: begin
          r_quo_res <= w_qres;
          r_rem_res <= r_div0 ? r_op1 : w_rres;
          r_state   <= S_DONE;
        end
        S_DONE: begin
          quo_o   <= r_quo_res;
          rem_o   <= r_rem_res;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_srt_r4.sv
// tb_srt_r4: directed checks of the radix-4 SRT divider plus a randomised pair sweep.
module tb_srt_r4;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rstn;
  logic [W-1:0] op1, op2, rem, quo;

  int n_cmp = 0;
  int n_bad = 0;

  srt_r4 #(.WIDTH(W)) dut (
    .clk   (clk),
    .rstn  (rstn),
    .op1_i (op1),
    .op2_i (op2),
    .rem_o (rem),
    .quo_o (quo)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Hold a pair for twice the latency so a full computation on it completes.
  task automatic apply(input logic [W-1:0] a, input logic [W-1:0] b);
    op1 = a;
    op2 = b;
    cycles(18);
  endtask

  initial begin
    logic [W-1:0] a, b;
    logic         seen;

    // Reset holds outputs at zero.
    rstn = 1'b0;
    op1  = 8'd23;
    op2  = 8'd7;
    cycles(3);
    check("rst_quo", {8'h00, quo}, 16'h0000);
    check("rst_rem", {8'h00, rem}, 16'h0000);

    // Latency: capture on the first edge after release, outputs load on the ninth.
    @(negedge clk);
    rstn = 1'b1;
    cycles(8);
    check("lat8", {quo, rem}, {8'd0, 8'd0});
    cycles(1);
    check("lat9", {quo, rem}, {8'd3, 8'd2});
    cycles(9);
    check("hold_23_7", {quo, rem}, {8'd3, 8'd2});

    // Directed boundary vectors.
    apply(8'd255, 8'd1);
    check("255_1", {quo, rem}, {8'd255, 8'd0});
    apply(8'd255, 8'd255);
    check("255_255", {quo, rem}, {8'd1, 8'd0});
    apply(8'd5, 8'd200);
    check("5_200", {quo, rem}, {8'd0, 8'd5});
    apply(8'd0, 8'd9);
    check("0_9", {quo, rem}, {8'd0, 8'd0});
    apply(8'd100, 8'd0);
    check("div0", {quo, rem}, {8'hFF, 8'd100});
    apply(8'd128, 8'd3);
    check("128_3", {quo, rem}, {8'd42, 8'd2});

    // Operand change mid-stream: outputs go 3/2 -> 15/5 once, with nothing in between.
    apply(8'd23, 8'd7);
    check("pre_switch", {quo, rem}, {8'd3, 8'd2});
    cycles(4);
    op1  = 8'd200;
    op2  = 8'd13;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      cycles(1);
      if (quo == 8'd15) seen = 1'b1;
      check("switch", {quo, rem}, seen ? {8'd15, 8'd5} : {8'd3, 8'd2});
    end
    check("switched", {15'd0, seen}, 16'd1);

    // Reset mid-operation clears outputs immediately, then the divider recovers.
    op1 = 8'd255;
    op2 = 8'd1;
    cycles(4);
    #2;
    rstn = 1'b0;
    #1;
    check("midrst", {quo, rem}, 16'h0000);
    @(negedge clk);
    rstn = 1'b1;
    apply(8'd200, 8'd13);
    check("recover", {quo, rem}, {8'd15, 8'd5});

    // Sweep: fixed corner pairs followed by random pairs, divisor nonzero.
    apply(8'd254, 8'd255);
    check("254_255", {quo, rem}, {8'd0, 8'd254});
    apply(8'd255, 8'd2);
    check("255_2", {quo, rem}, {8'd127, 8'd1});
    apply(8'd127, 8'd128);
    check("127_128", {quo, rem}, {8'd0, 8'd127});
    apply(8'd255, 8'd16);
    check("255_16", {quo, rem}, {8'd15, 8'd15});
    for (int i = 0; i < 3000; i++) begin
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(1, 255));
      apply(a, b);
      check($sformatf("sweep_%0d_%0d", a, b), {quo, rem}, {a / b, a % b});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
